// File: rtl/mux_pkg.sv
// Shared definitions for the registered 4:1 multiplexer and its bench.
//   sel_t        2-bit select, {s1,s2} with s1 as the MSB
//   SEL_A..SEL_D select codes for operands a..d
//   make_sel()   packs the two select bits into a sel_t
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  function automatic sel_t make_sel(input logic s1, input logic s2);
    return sel_t'({s1, s2});
  endfunction

endpackage

// File: rtl/mux_4to1_if.sv
// Bus bundle for mux_4to1.
//   a, b, c, d  WIDTH-bit operands
//   s1, s2      select bits (s1 = MSB)
//   in_valid    capture strobe
//   out         registered selected operand
//   out_valid   high the cycle after a capture
// master: drives operands/select/strobe (producer side).
// slave : the multiplexer itself.
interface mux_4to1_if #(
  parameter int unsigned WIDTH = 1
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             s1;
  logic             s2;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;

  modport master (
    output a, b, c, d, s1, s2, in_valid,
    input  out, out_valid
  );

  modport slave (
    input  a, b, c, d, s1, s2, in_valid,
    output out, out_valid
  );

endinterface

// File: rtl/mux4_comb.sv
// Pure combinational 4:1 selector.
//   a, b, c, d  in   WIDTH  operands
//   sel         in   2      select code (sel_t)
//   y           out  WIDTH  selected operand, bit-exact
module mux4_comb
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  sel_t             sel,
  output logic [WIDTH-1:0] y
);

  // The default arm doubles as the SEL_A decode so every code, legal or not,
  // resolves to a defined operand and no latch can be inferred.
  always_comb begin
    y = a;
    case (sel)
      SEL_B:   y = b;
      SEL_C:   y = c;
      SEL_D:   y = d;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux_4to1.sv
// Registered 4:1 data multiplexer with a valid flag and one cycle of latency.
//   clk    in   rising-edge clock
//   rst_n  in   synchronous active-low reset (priority over capture)
//   bus    slave modport of mux_4to1_if; WIDTH must match this module's WIDTH
// On an edge with in_valid=1 the selected operand is captured into out and
// out_valid goes high for the following cycle; otherwise out holds and
// out_valid drops.
module mux_4to1
  import mux_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_4to1_if.slave   bus
);

  sel_t             sel;
  logic [WIDTH-1:0] mux_data;
  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  assign sel = make_sel(bus.s1, bus.s2);

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_mux4_comb (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .sel (sel),
    .y   (mux_data)
  );

  // Select or data changes without in_valid never reach the register.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (bus.in_valid) begin
      out_d   = mux_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_4to1.sv
// Randomised self-checking bench for mux_4to1: a WIDTH=4 and a WIDTH=1 instance
// share clock and reset and are compared every cycle against a reference model
// that picks the operand from an array indexed by the select value.
module tb_mux_4to1;
  import mux_pkg::*;

  logic clk;
  logic rst_n;

  mux_4to1_if #(.WIDTH(4)) bus4 ();
  mux_4to1_if #(.WIDTH(1)) bus1 ();

  mux_4to1 #(
    .WIDTH   (4),
    .RST_VAL (4'h0)
  ) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  mux_4to1 #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: what each output should hold after the next edge.
  logic [3:0] m_out4;
  logic       m_val4;
  logic       m_out1;
  logic       m_val1;

  sel_t sel4;
  sel_t sel1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply current inputs across one rising edge, update the model, compare.
  task automatic tick(input string tag);
    logic [3:0] ops4 [4];
    logic       ops1 [4];
    bus4.s1 = sel4[1];
    bus4.s2 = sel4[0];
    bus1.s1 = sel1[1];
    bus1.s2 = sel1[0];
    ops4[0] = bus4.a; ops4[1] = bus4.b; ops4[2] = bus4.c; ops4[3] = bus4.d;
    ops1[0] = bus1.a; ops1[1] = bus1.b; ops1[2] = bus1.c; ops1[3] = bus1.d;
    if (!rst_n) begin
      m_out4 = 4'h0; m_val4 = 1'b0;
      m_out1 = 1'b0; m_val1 = 1'b0;
    end else begin
      if (bus4.in_valid) m_out4 = ops4[int'(sel4)];
      m_val4 = bus4.in_valid;
      if (bus1.in_valid) m_out1 = ops1[int'(sel1)];
      m_val1 = bus1.in_valid;
    end
    @(posedge clk);
    #1;
    check_eq({tag, "_out4"}, 64'(bus4.out), 64'(m_out4));
    check_eq({tag, "_val4"}, 64'(bus4.out_valid), 64'(m_val4));
    check_eq({tag, "_out1"}, 64'(bus1.out), 64'(m_out1));
    check_eq({tag, "_val1"}, 64'(bus1.out_valid), 64'(m_val1));
  endtask

  task automatic rand_ops4();
    bus4.a = 4'($urandom); bus4.b = 4'($urandom);
    bus4.c = 4'($urandom); bus4.d = 4'($urandom);
    sel4   = sel_t'($urandom_range(3, 0));
  endtask

  task automatic rand_ops1();
    bus1.a = 1'($urandom); bus1.b = 1'($urandom);
    bus1.c = 1'($urandom); bus1.d = 1'($urandom);
    sel1   = sel_t'($urandom_range(3, 0));
  endtask

  initial begin
    // Reset held 3 cycles with a capture request pending.
    rst_n = 1'b0;
    bus4.a = 4'd1; bus4.b = 4'd0; bus4.c = 4'd0; bus4.d = 4'd0;
    bus1.a = 1'b1; bus1.b = 1'b0; bus1.c = 1'b0; bus1.d = 1'b0;
    sel4 = SEL_A; sel1 = SEL_A;
    bus4.in_valid = 1'b1;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("reset");
      check_eq("reset_const_out", 64'(bus4.out), 64'h0);
    end

    // Select sweep with one-hot operands.
    rst_n  = 1'b1;
    bus4.a = 4'd1; bus4.b = 4'd2; bus4.c = 4'd4; bus4.d = 4'd8;
    for (int s = 0; s < 4; s++) begin
      sel4 = sel_t'(s);
      tick("sweep");
      check_eq("sweep_const", 64'(bus4.out), 64'(1 << s));
    end

    // Hold: capture c, then drop in_valid and move select to d.
    sel4 = SEL_C;
    tick("hold_cap");
    bus4.in_valid = 1'b0;
    sel4 = SEL_D;
    bus4.d = 4'd8;
    tick("hold0");
    tick("hold1");
    check_eq("hold_const", 64'(bus4.out), 64'd4);

    // Back-to-back random captures.
    bus4.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops4();
      rand_ops1();
      tick("b2b");
    end

    // One-cycle reset in the middle of a stream.
    rand_ops4(); rand_ops1();
    tick("pre_rst");
    rst_n = 1'b0;
    rand_ops4(); rand_ops1();
    tick("mid_rst");
    check_eq("mid_rst_const", 64'(bus4.out_valid), 64'h0);
    rst_n = 1'b1;
    rand_ops4(); rand_ops1();
    tick("post_rst");

    // Random mix of strobes and occasional resets.
    for (int i = 0; i < 60; i++) begin
      rand_ops4();
      rand_ops1();
      bus4.in_valid = 1'($urandom);
      bus1.in_valid = 1'($urandom);
      rst_n = ($urandom_range(15, 0) != 0);
      tick("mix");
    end

    // Exhaustive WIDTH=1: every combination of a,b,c,d,s1,s2.
    rst_n = 1'b1;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = 6'(i);
      bus1.a = v[5]; bus1.b = v[4]; bus1.c = v[3]; bus1.d = v[2];
      sel1 = sel_t'(v[1:0]);
      rand_ops4();
      bus4.in_valid = 1'($urandom);
      tick("exh");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
